// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display scanner.
// Segment patterns are gfedcba, active-low.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [3:0] ANODE_OFF  = 4'hF;
   localparam int         NUM_DIGITS = 4;

   // Active-low one-hot anode enable for a digit index.
   function automatic logic [3:0] anode_for(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/seg7_display_scanner_bcd_to_seg7.sv
// Combinational BCD code to active-low gfedcba pattern; codes 10..15 render as a dash.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      if (blank) begin
         seg = SEG_BLANK;
      end else begin
         case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/seg7_display_scanner.sv
// 4-digit common-anode display scanner with per-frame input snapshot, decimal points
// and optional leading-zero blanking. All outputs are registered from next-state values.
module seg7_display_scanner
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV   = 100000,
   parameter int DIV_WIDTH     = 17,
   parameter int BLANK_LEADING = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ENABLE,
   input  logic [15:0] BCD_IN,
   input  logic [3:0]  DOT_IN,
   output logic [7:0]  SEG_OUT,
   output logic [3:0]  ANODE_OUT,
   output logic [1:0]  DIGIT_SEL
);

   localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(REFRESH_DIV - 1);

   logic [DIV_WIDTH-1:0] prescaler;
   logic [DIV_WIDTH-1:0] prescaler_nx;
   logic [1:0]           index;
   logic [1:0]           index_nx;
   logic [15:0]          shadow_bcd;
   logic [15:0]          bcd_nx;
   logic [3:0]           shadow_dot;
   logic [3:0]           dot_nx;
   logic                 running;
   logic                 tick;
   logic                 load;
   logic [3:0]           digit_nx;
   logic                 blank_nx;
   logic [6:0]           seg_nx;

   // Next-state values are only committed while ENABLE is high.
   always_comb begin
      tick         = (prescaler == DIV_LAST);
      load         = !running || (tick && (index == 2'd3));
      prescaler_nx = tick ? '0 : prescaler + DIV_WIDTH'(1);
      index_nx     = tick ? index + 2'd1 : index;
      bcd_nx       = load ? BCD_IN : shadow_bcd;
      dot_nx       = load ? DOT_IN : shadow_dot;
      digit_nx     = bcd_nx[{index_nx, 2'b00} +: 4];
   end

   // Leading-zero blanking looks at the snapshot that the digit will actually show.
   always_comb begin
      blank_nx = 1'b0;
      case (index_nx)
         2'd3: blank_nx = (bcd_nx[15:12] == 4'd0);
         2'd2: blank_nx = (bcd_nx[15:8] == 8'd0);
         2'd1: blank_nx = (bcd_nx[15:4] == 12'd0);
         default: blank_nx = 1'b0;
      endcase
      if (BLANK_LEADING == 0) blank_nx = 1'b0;
   end

   bcd_to_seg7 u_decode (
      .code  (digit_nx),
      .blank (blank_nx),
      .seg   (seg_nx)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         prescaler  <= '0;
         index      <= 2'd0;
         shadow_bcd <= 16'd0;
         shadow_dot <= 4'd0;
         running    <= 1'b0;
         SEG_OUT    <= {1'b1, SEG_BLANK};
         ANODE_OUT  <= ANODE_OFF;
         DIGIT_SEL  <= 2'd0;
      end else if (ENABLE) begin
         prescaler  <= prescaler_nx;
         index      <= index_nx;
         shadow_bcd <= bcd_nx;
         shadow_dot <= dot_nx;
         running    <= 1'b1;
         SEG_OUT    <= {~dot_nx[index_nx], seg_nx};
         ANODE_OUT  <= anode_for(index_nx);
         DIGIT_SEL  <= index_nx;
      end else begin
         // Dark display; prescaler, index and DIGIT_SEL hold for a seamless resume.
         running    <= 1'b0;
         SEG_OUT    <= {1'b1, SEG_BLANK};
         ANODE_OUT  <= ANODE_OFF;
      end
   end

endmodule

// File: tb/tb_seg7_display_scanner.sv
// Scoreboard bench: stimulus queues expected digit slots, a monitor checks every output change.
module tb_seg7_display_scanner;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        ENABLE = 1'b0;
   logic [15:0] BCD_IN = 16'd0;
   logic [3:0]  DOT_IN = 4'd0;
   logic [7:0]  seg, seg_nb;
   logic [3:0]  an, an_nb;
   logic [1:0]  sel, sel_nb;

   typedef struct {
      logic [3:0] an;
      logic [7:0] seg;
      logic [1:0] sel;
      logic [7:0] seg_nb;
      int         gap;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   seg7_display_scanner #(.REFRESH_DIV(4), .DIV_WIDTH(2), .BLANK_LEADING(1)) dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .BCD_IN(BCD_IN), .DOT_IN(DOT_IN),
      .SEG_OUT(seg), .ANODE_OUT(an), .DIGIT_SEL(sel)
   );

   seg7_display_scanner #(.REFRESH_DIV(4), .DIV_WIDTH(2), .BLANK_LEADING(0)) dut_nb (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .BCD_IN(BCD_IN), .DOT_IN(DOT_IN),
      .SEG_OUT(seg_nb), .ANODE_OUT(an_nb), .DIGIT_SEL(sel_nb)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic expect_slot(input logic [3:0] e_an, input logic [7:0] e_seg,
                              input logic [1:0] e_sel, input logic [7:0] e_seg_nb, input int gap);
      exp_t e;
      e.an = e_an; e.seg = e_seg; e.sel = e_sel; e.seg_nb = e_seg_nb; e.gap = gap;
      sb.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(posedge CLK); #2;
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s timeout pending=%0d", name, sb.size());
         sb.delete();
      end
   endtask

   // Monitor: every change of the output tuple must match the next queued slot.
   initial begin
      logic [25:0] prev;
      logic [25:0] cur;
      int          last_cyc;
      exp_t        e;
      prev = {4'hF, 8'hFF, 2'd0, 4'hF, 8'hFF};
      last_cyc = 0;
      forever begin
         @(negedge CLK);
         cur = {an, seg, sel, an_nb, seg_nb};
         if (cur !== prev) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_change actual an=%b seg=%h sel=%0d", an, seg, sel);
            end else begin
               e = sb.pop_front();
               checks++;
               if (cur !== {e.an, e.seg, e.sel, e.an, e.seg_nb}) begin
                  failures++;
                  $display("FAIL slot actual an=%b seg=%h sel=%0d an_nb=%b seg_nb=%h required an=%b seg=%h sel=%0d seg_nb=%h",
                           an, seg, sel, an_nb, seg_nb, e.an, e.seg, e.sel, e.seg_nb);
               end
               if (e.gap != 0) begin
                  checks++;
                  if (cyc - last_cyc != e.gap) begin
                     failures++;
                     $display("FAIL slot_len sel=%0d actual=%0d required=%0d", e.sel, cyc - last_cyc, e.gap);
                  end
               end
            end
            prev = cur;
            last_cyc = cyc;
         end
      end
   end

   initial begin
      #1 RESET = 1'b1;
      #1;
      check("reset_anode", 32'(an), 32'hF);
      check("reset_seg", 32'(seg), 32'hFF);
      check("reset_sel", 32'(sel), 32'h0);
      check("reset_seg_nb", 32'(seg_nb), 32'hFF);

      // Basic scan of 1234
      expect_slot(4'b1110, 8'h99, 2'd0, 8'h99, 0);
      expect_slot(4'b1101, 8'hB0, 2'd1, 8'hB0, 3);
      expect_slot(4'b1011, 8'hA4, 2'd2, 8'hA4, 4);
      expect_slot(4'b0111, 8'hF9, 2'd3, 8'hF9, 4);
      expect_slot(4'b1110, 8'h99, 2'd0, 8'h99, 4);
      @(posedge CLK); #1;
      RESET = 1'b0; ENABLE = 1'b1; BCD_IN = 16'h1234; DOT_IN = 4'd0;
      wait_drain("scan_1234");

      // 0070 mid-frame: current frame finishes with 1234, then blanking applies
      BCD_IN = 16'h0070;
      expect_slot(4'b1101, 8'hB0, 2'd1, 8'hB0, 4);
      expect_slot(4'b1011, 8'hA4, 2'd2, 8'hA4, 4);
      expect_slot(4'b0111, 8'hF9, 2'd3, 8'hF9, 4);
      expect_slot(4'b1110, 8'hC0, 2'd0, 8'hC0, 4);
      expect_slot(4'b1101, 8'hF8, 2'd1, 8'hF8, 4);
      expect_slot(4'b1011, 8'hFF, 2'd2, 8'hC0, 4);
      expect_slot(4'b0111, 8'hFF, 2'd3, 8'hC0, 4);
      wait_drain("blank_0070");

      // Change 1234 -> 5678 during digit1: no tearing
      BCD_IN = 16'h1234;
      expect_slot(4'b1110, 8'h99, 2'd0, 8'h99, 4);
      expect_slot(4'b1101, 8'hB0, 2'd1, 8'hB0, 4);
      wait_drain("reload_1234");
      BCD_IN = 16'h5678;
      expect_slot(4'b1011, 8'hA4, 2'd2, 8'hA4, 4);
      expect_slot(4'b0111, 8'hF9, 2'd3, 8'hF9, 4);
      expect_slot(4'b1110, 8'h80, 2'd0, 8'h80, 4);
      expect_slot(4'b1101, 8'hF8, 2'd1, 8'hF8, 4);
      expect_slot(4'b1011, 8'h82, 2'd2, 8'h82, 4);
      expect_slot(4'b0111, 8'h92, 2'd3, 8'h92, 4);
      wait_drain("no_tear");

      // Invalid code with decimal point
      BCD_IN = 16'h00A0; DOT_IN = 4'b0010;
      expect_slot(4'b1110, 8'hC0, 2'd0, 8'hC0, 4);
      expect_slot(4'b1101, 8'h3F, 2'd1, 8'h3F, 4);
      expect_slot(4'b1011, 8'hFF, 2'd2, 8'hC0, 4);
      expect_slot(4'b0111, 8'hFF, 2'd3, 8'hC0, 4);
      wait_drain("dash_dot");

      // Drop ENABLE during digit2, resume after 10 cycles
      BCD_IN = 16'h1234; DOT_IN = 4'd0;
      expect_slot(4'b1110, 8'h99, 2'd0, 8'h99, 4);
      expect_slot(4'b1101, 8'hB0, 2'd1, 8'hB0, 4);
      expect_slot(4'b1011, 8'hA4, 2'd2, 8'hA4, 4);
      wait_drain("pre_disable");
      expect_slot(4'b1111, 8'hFF, 2'd2, 8'hFF, 2);
      expect_slot(4'b1011, 8'hA4, 2'd2, 8'hA4, 0);
      expect_slot(4'b0111, 8'hF9, 2'd3, 8'hF9, 2);
      expect_slot(4'b1110, 8'h99, 2'd0, 8'h99, 4);
      ENABLE = 1'b0;
      repeat (10) @(posedge CLK);
      #1 ENABLE = 1'b1;
      wait_drain("enable_resume");

      // Asynchronous reset mid-frame
      expect_slot(4'b1111, 8'hFF, 2'd0, 8'hFF, 0);
      RESET = 1'b1;
      #1;
      check("midreset_anode", 32'(an), 32'hF);
      check("midreset_seg", 32'(seg), 32'hFF);
      check("midreset_sel", 32'(sel), 32'h0);
      repeat (3) @(posedge CLK);
      #1;
      expect_slot(4'b1110, 8'h99, 2'd0, 8'h99, 0);
      expect_slot(4'b1101, 8'hB0, 2'd1, 8'hB0, 3);
      RESET = 1'b0;
      wait_drain("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
